odd_one_out_param: RTL

//  Parametrised successor of the single-set odd-one-out finder.

---
 rtl/odd_one_out_pkg.sv | 27 ++
 rtl/odd_one_out_param_latch_conditioner.sv | 74 +++++++
 rtl/odd_one_out_param.sv | 95 +++++++++
 3 files changed

// File: rtl/odd_one_out_pkg.sv
// Shared definitions for the odd-one-out finder: default widths, the FSM
// state encoding and the debounce counter width helper.
// Optional feature macro: DEBOUNCE_EN (consumed by latch_conditioner).
package odd_one_out_pkg;

    localparam int unsigned W_DEF         = 8;
    localparam int unsigned CW_DEF        = 8;
    localparam int unsigned DB_CYCLES_DEF = 1000000;

    // Fixed 2-bit codes so existing logic-analyser decodes keep working.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        COLLECT = ST_COLLECT,
        DONE    = ST_DONE
    } state_t;

    function automatic int unsigned db_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int unsigned DB_CW = db_width(DB_CYCLES_DEF);

endpackage

// File: rtl/odd_one_out_param_latch_conditioner.sv
// latch_conditioner: turns the raw push-button level into a single-cycle
// `take` pulse per press.
//   clk      in  system clock
//   reset    in  asynchronous active-high reset
//   latch_in in  raw button level (asynchronous to clk)
//   take     out one-cycle pulse per accepted rising edge
// Path: 2-flop synchroniser -> optional debounce filter (DEBOUNCE_EN) ->
// registered rising-edge detect. Without the filter, take rises 3 clocks
// after the raw edge; with it, DB_CYCLES+3 clocks.
module latch_conditioner
    import odd_one_out_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic latch_in,
    output logic take
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= latch_in;
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned CNT_W = db_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt;
    logic             filt;

    // Count consecutive cycles the synchronised level disagrees with the
    // filtered level; any return to agreement restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt <= '0;
            filt   <= 1'b0;
        end else if (sync2 == filt) begin
            db_cnt <= '0;
        end else if (db_cnt == LAST) begin
            filt   <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_d <= 1'b0;
            take    <= 1'b0;
        end else begin
            level_d <= level;
            take    <= level & ~level_d;
        end
    end

endmodule

// File: rtl/odd_one_out_param.sv
// odd_one_out_param: accepts count_n operands of W bits, one per button
// press, XOR-accumulates them and reports the value occurring an odd number
// of times.
//   clk       in  system clock
//   reset     in  asynchronous active-high reset
//   data_in   in  [W]  operand sampled when a take is processed
//   count_n   in  [CW] operands per set, sampled on the first take of a set
//   latch_in  in  raw button level
//   result    out [W]  XOR of the last completed set
//   ready     out high while result holds a completed set
//   count_err out high if the set was started with count_n zero or even
// Optional feature macro: DEBOUNCE_EN (button debounce, DB_CYCLES cycles).
module odd_one_out_param
    import odd_one_out_pkg::*;
#(
    parameter int unsigned W         = W_DEF,
    parameter int unsigned CW        = CW_DEF,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  data_in,
    input  logic [CW-1:0] count_n,
    input  logic          latch_in,
    output logic [W-1:0]  result,
    output logic          ready,
    output logic          count_err
);

    logic          take;
    state_t        state;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic [CW-1:0] n_reg;
    logic [CW-1:0] cnt_inc;

    latch_conditioner #(
        .DB_CYCLES (DB_CYCLES)
    ) u_cond (
        .clk      (clk),
        .reset    (reset),
        .latch_in (latch_in),
        .take     (take)
    );

    // cnt stays below n_reg, so the increment never wraps.
    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            n_reg     <= '0;
            result    <= '0;
            ready     <= 1'b0;
            count_err <= 1'b0;
        end else if (take) begin
            case (state)
                IDLE, DONE: begin
                    if (count_n == '0) begin
                        // Edge ignored apart from flagging the bad count.
                        count_err <= 1'b1;
                    end else if (count_n == CW'(1)) begin
                        result    <= data_in;
                        ready     <= 1'b1;
                        count_err <= 1'b0;
                        state     <= DONE;
                    end else begin
                        n_reg     <= count_n;
                        acc       <= data_in;
                        cnt       <= CW'(1);
                        ready     <= 1'b0;
                        count_err <= ~count_n[0];
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (cnt_inc == n_reg) begin
                        result <= acc ^ data_in;
                        ready  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        acc <= acc ^ data_in;
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
